// File: rtl/veda_pkg.sv
// Shared definitions for the veda two-requester memory arbiter.
// Widths, memory mode encodings and the flush FSM state type.
package veda_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic SCRIBBLE  = 1'b0;
    localparam logic INTERPRET = 1'b1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/veda_rd_track.sv
// Read-return tracker: two-stage valid+ID shift pipeline that
// matches the memory's two-cycle registered read path; never stalls.
module veda_rd_track
    import veda_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_issue,
    input  logic       rd_id,
    output logic [1:0] rvalid,
    output logic       drain_empty
);

    rd_tag_t s1_q, s1_d;
    rd_tag_t s2_q, s2_d;

    always_comb begin
        s1_d.vld = rd_issue;
        s1_d.id  = rd_id;
        s2_d     = s1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rvalid[0] = s2_q.vld & ~s2_q.id;
    assign rvalid[1] = s2_q.vld &  s2_q.id;

    // The last stage retires this cycle, so only stage 1 can hold back a flush.
    assign drain_empty = ~s1_q.vld;

endmodule

// File: rtl/veda_arbiter.sv
// Two-requester single-port memory arbiter with flush/quiesce FSM.
// Define VEDA_ARB_RR_EN for round-robin; default is fixed priority (req 0 wins).
module veda_arbiter
    import veda_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                mem_write_enable,
    output logic [ADDR_W-1:0]   mem_address_a,
    output logic [ADDR_W-1:0]   mem_address_b,
    output logic [DATA_W-1:0]   mem_data_in,
    output logic                mem_mode,
    input  logic [DATA_W-1:0]   mem_data_out
);

    state_e state_q, state_d;
    logic   run_ok;
    logic   drain_empty;
    logic   sel;
    logic   we_sel;
    logic   wr_go;
    logic   rd_go;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    // Gating with reset_n keeps the combinational grant quiet during reset.
    assign run_ok = (state_q == RUN) & ~flush_req & reset_n;

`ifdef VEDA_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (run_ok) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        last_d = last_q;
        if (|gnt) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (run_ok) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end
`endif

    assign sel = gnt[1];

    always_comb begin
        addr_sel  = sel ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
        wdata_sel = sel ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
        we_sel    = sel ? we[1] : we[0];
        wr_go     = (|gnt) & we_sel;
        rd_go     = (|gnt) & ~we_sel;

        mem_write_enable = wr_go;
        mem_mode         = wr_go ? SCRIBBLE : INTERPRET;
        mem_address_a    = wr_go ? addr_sel : '0;
        mem_data_in      = wr_go ? wdata_sel : '0;
        mem_address_b    = rd_go ? addr_sel : '0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!flush_req) begin
                    state_d = RUN;
                end else if (drain_empty) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (!flush_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign flush_done = (state_q == HALT);
    assign rdata      = mem_data_out;

    veda_rd_track u_rd_track (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_issue    (rd_go),
        .rd_id       (sel),
        .rvalid      (rvalid),
        .drain_empty (drain_empty)
    );

endmodule
